uart_transmitter: RTL and testbench

8N1 UART serializer that pairs with the codebase's UART receiver on the same serial line. It accepts bytes through a valid/ready handshake into a one-entry holding register. It shifts each byte out LSB-first at a bit period that exactly matches the receiver's oversampled timing. The block sits between on-chip byte producers and the `txd` pad, and supports back-to-back frames with no idle gap.

---
 rtl/uart_transmitter.sv | 112 +++++++++++
 tb/tb_uart_transmitter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART serializer with a one-byte holding register and valid/ready input.
// Defining UART_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module uart_transmitter #(
   parameter int CLK_FREQ   = 1000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DIV_SAMPLE = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       txd,
   output logic       busy,
   output logic       tx_done
);
   localparam int BIT_CYCLES = (CLK_FREQ / (BAUD_RATE * DIV_SAMPLE)) * DIV_SAMPLE;
   localparam int CW = $clog2(BIT_CYCLES);
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] idx, idx_n;
   logic [7:0] shift, shift_n, hold;
   logic hold_full, load, txd_n, bit_end, hs;
   assign bit_end  = cnt == CW'(BIT_CYCLES - 1);
   assign tx_ready = !hold_full;
   assign hs       = tx_valid && tx_ready;
   assign busy     = state != IDLE;
   assign tx_done  = state == STOP && bit_end;
`ifdef UART_TX_PARITY_EN
   logic par;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) par <= 1'b0;
      else if (load) par <= ^hold;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shift     <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         txd       <= 1'b1;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         shift     <= shift_n;
         txd       <= txd_n;
         hold      <= hs ? tx_data : hold;
         hold_full <= hs || (hold_full && !load);
      end
   // txd_n is the level of the next bit so txd itself stays a plain flop
   always_comb begin
      state_n = state;
      cnt_n   = cnt + CW'(1);
      idx_n   = idx;
      shift_n = shift;
      txd_n   = txd;
      load    = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (hold_full) begin
               state_n = START;
               load    = 1'b1;
               txd_n   = 1'b0;
            end
         end
         START: if (bit_end) begin
            state_n = DATA;
            cnt_n   = '0;
            idx_n   = '0;
            txd_n   = shift[0];
         end
         DATA: if (bit_end) begin
            cnt_n   = '0;
            shift_n = shift >> 1;
            idx_n   = idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_n = PARITY;
               txd_n   = par;
`else
               state_n = STOP;
               txd_n   = 1'b1;
`endif
            end else txd_n = shift[1];
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_end) begin
            state_n = STOP;
            cnt_n   = '0;
            txd_n   = 1'b1;
         end
`endif
         STOP: if (bit_end) begin
            cnt_n   = '0;
            state_n = hold_full ? START : IDLE;
            load    = hold_full;
            txd_n   = !hold_full;
         end
         default: state_n = IDLE;
      endcase
      if (load) shift_n = hold;
   end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: table-driven and scoreboard checks of uart_transmitter framing, timing and reset.
module tb_uart_transmitter;
   localparam int BC = 104;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FL = NB * BC;
   typedef struct {logic [7:0] data; logic par;} vec_t;
   logic clk = 0, rst_n = 0, tx_valid = 0;
   logic [7:0] tx_data = 0;
   logic tx_ready, txd, busy, tx_done;
   int tests = 0, fails = 0, cyc = 0, hs = 0, fc = -1;
   bit mon_en = 0;
   logic [10:0] bits;
   vec_t sbq[$];
   int starts[$];
   vec_t vt[8];

   uart_transmitter dut (.clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .txd(txd), .busy(busy), .tx_done(tx_done));

   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc++;
      if (rst_n && tx_valid && tx_ready) hs++;
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // frame decoder: samples each bit mid-period, checks tx_done on the last stop clock
   always @(negedge clk) begin
      vec_t e;
      if (!mon_en) fc = -1;
      else begin
         if (fc < 0 && txd === 1'b0) begin
            fc = 0;
            starts.push_back(cyc);
         end
         if (fc >= 0) begin
            if (fc % BC == BC / 2) bits[fc / BC] = txd;
            if (fc == FL - 2) chk("tx_done_early", tx_done, 0);
            if (fc == FL - 1) begin
               chk("tx_done", tx_done, 1);
               chk("start_bit", bits[0], 0);
               chk("stop_bit", bits[NB-1], 1);
               if (sbq.size() == 0) chk("unexpected_frame", bits[8:1], 32'hx);
               else begin
                  e = sbq.pop_front();
                  chk("frame_data", bits[8:1], e.data);
`ifdef UART_TX_PARITY_EN
                  chk("parity_bit", bits[9], e.par);
`endif
               end
               fc = -1;
            end else fc++;
         end
      end
   end

   task automatic send(input logic [7:0] b, input logic p, output int waited);
      tx_data  = b;
      tx_valid = 1;
      waited   = 0;
      while (!tx_ready && waited < 3 * FL) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 3 * FL) chk("handshake_timeout", waited, 0);
      else sbq.push_back('{b, p});
      @(negedge clk);
      tx_valid = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || sbq.size() != 0) && n < 5 * FL) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5 * FL) chk("idle_timeout", n, 0);
   endtask

   initial begin
      int w, h0;
      vt = '{'{8'hA5, 1'b0}, '{8'h07, 1'b1}, '{8'h00, 1'b0}, '{8'h55, 1'b0},
             '{8'hFF, 1'b0}, '{8'h3C, 1'b0}, '{8'h80, 1'b1}, '{8'h01, 1'b1}};
      repeat (3) @(negedge clk);
      chk("rst_txd", txd, 1);
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", tx_done, 0);
      rst_n  = 1;
      mon_en = 1;
      repeat (5) @(negedge clk);
      foreach (vt[i]) begin
         send(vt[i].data, vt[i].par, w);
         chk("lat_txd_hi", txd, 1);
         chk("lat_busy_lo", busy, 0);
         chk("lat_ready_lo", tx_ready, 0);
         @(negedge clk);
         chk("lat_txd_lo", txd, 0);
         chk("lat_busy_hi", busy, 1);
         chk("lat_ready_hi", tx_ready, 1);
         wait_idle();
         repeat (3) @(negedge clk);
      end
      starts.delete();
      send(8'h00, 1'b0, w);
      send(8'hFF, 1'b0, w);
      chk("b2b_second_wait", w, 1);
      chk("b2b_ready_after", tx_ready, 0);
      send(8'h3C, 1'b0, w);
      wait_idle();
      chk("b2b_frames", starts.size(), 3);
      if (starts.size() == 3) begin
         chk("b2b_gap1", starts[1] - starts[0], FL);
         chk("b2b_gap2", starts[2] - starts[1], FL);
      end
      repeat (3) @(negedge clk);
      h0 = hs;
      send(8'h11, 1'b0, w);
      send(8'h22, 1'b0, w);
      send(8'h5A, 1'b0, w);
      chk("stall_long", w >= 500, 1);
      wait_idle();
      chk("stall_handshakes", hs - h0, 3);
      repeat (3) @(negedge clk);
      send(8'h81, 1'b0, w);
      send(8'h42, 1'b0, w);
      w = 0;
      while (fc != 300 && w < 3 * FL) begin
         @(negedge clk);
         w++;
      end
      chk("reach_300", fc, 300);
      #2 rst_n = 0;
      mon_en = 0;
      #1;
      chk("abort_txd", txd, 1);
      chk("abort_busy", busy, 0);
      chk("abort_ready", tx_ready, 1);
      chk("abort_done", tx_done, 0);
      sbq.delete();
      @(negedge clk);
      rst_n = 1;
      repeat (2 * BC) @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_txd", txd, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
